uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clk cycles per serial bit; legal values are even and >= 4.
REQ-002 SHALL have parameter DATA_BITS, default 8, payload bits per frame; fixed at 8 in this revision.
REQ-003 SHALL have port clk, input, 1, single clock; all state on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-005 SHALL have port rx, input, 1, asynchronous serial line, idle high, driven by uart_tx tx.
REQ-006 SHALL have port rx_ready, input, 1, consumer accepts rx_data when high together with rx_valid.
REQ-007 SHALL have port rx_data, output, 8, last received byte, stable while rx_valid is high.
REQ-008 SHALL have port rx_valid, output, 1, rx_data holds an unconsumed byte.
REQ-009 SHALL have port rx_busy, output, 1, high in every state except IDLE.
REQ-010 SHALL have port frame_err, output, 1, one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port overrun_err, output, 1, one-cycle pulse when a completed byte is dropped.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer, initialised high, before any use; all timing below refers to the synchronized signal rx_s.
REQ-013 SHALL implement states IDLE, START, DATA, STOP.
REQ-014 SHALL leave IDLE for START on a 1-to-0 transition of rx_s, clearing the bit-period counter.
REQ-015 SHALL, in START, sample rx_s at counter = CLKS_PER_BIT/2-1: low -> DATA with counter cleared; high -> IDLE with no flag (glitch rejection).
REQ-016 SHALL, in DATA, sample rx_s every CLKS_PER_BIT cycles and shift it in LSB first; after the 8th sample -> STOP.
REQ-017 SHALL, in STOP, sample rx_s after CLKS_PER_BIT cycles and return to IDLE on the next edge.
REQ-018 SHALL, on stop sample = 1, load rx_data and set rx_valid on the same edge, provided rx_valid is low or rx_ready is high in that cycle.
REQ-019 SHALL, on stop sample = 1 with rx_valid high and rx_ready low, keep the old rx_data and pulse overrun_err for one cycle.
REQ-020 SHALL, on stop sample = 0, discard the byte, leave rx_valid and rx_data unchanged, and pulse frame_err for one cycle.
REQ-021 SHALL clear rx_valid on the edge where rx_valid and rx_ready are both high, unless a new byte loads on that same edge, in which case rx_valid stays high with the new data.
REQ-022 SHALL not restart after a frame error until rx_s has returned high and then falls again (edge-triggered start only).
REQ-023 SHALL assert rx_valid 154 cycles after the first clk edge on which rx is low, for CLKS_PER_BIT=16 (2 sync + 8 + 9*16).
REQ-024 SHALL size the bit-period counter to clog2(CLKS_PER_BIT) bits and the bit index to 3 bits, with no wrap beyond terminal counts.

Reset
REQ-025 SHALL, while reset = 0, force state IDLE, counters 0, shift register 0, synchronizer flops 1, rx_data 8'h00, and rx_valid, rx_busy, frame_err, overrun_err all 0.
REQ-026 SHALL abandon a frame in progress when reset asserts, flag no error, and require a fresh start edge after release.

Structure
REQ-027 SHALL take the state enum, UART_DATA_BITS and the default CLKS_PER_BIT from shared package uart_pkg, which uart_tx also uses.
REQ-028 SHALL place the 2-flop synchronizer in sub-module uart_rx_sync (ports clk, reset, d, q; reset value parameterised, 1 here).

Verification
REQ-029 SHALL verify: frame 0xA5 (start, 1,0,1,0,0,1,0,1 LSB-first, stop) at CLKS_PER_BIT=16 with rx_ready=1 -> rx_data=0xA5 and rx_valid high at cycle 154, cleared the next cycle.
REQ-030 SHALL verify: a 4-cycle low glitch on idle rx -> no rx_valid, no frame_err, and rx_busy low again by cycle 11.
REQ-031 SHALL verify: frame 0x3C with stop bit 0 -> frame_err single pulse, rx_valid stays 0, and the next valid frame 0x81 is received correctly.
REQ-032 SHALL verify: rx_ready held 0 while two frames 0x11 then 0x22 are sent -> rx_data stays 0x11 and overrun_err pulses once at the second stop sample.
REQ-033 SHALL verify: rx_ready pulsed high on the exact cycle the second byte 0x22 loads -> no overrun and rx_data=0x22 with rx_valid high.
REQ-034 SHALL verify: reset driven low mid-DATA of frame 0xFF -> all outputs return to reset values, and the subsequent frame 0x5A is received intact.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter.
package uart_pkg;

  // Payload width; only 8-bit frames are supported.
  localparam int unsigned UART_DATA_BITS = 8;

  // Default oversampling ratio: clk cycles per serial bit.
  localparam int unsigned UART_CLKS_PER_BIT = 16;

  // Frame-level FSM states.
  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Both stages reset to RESET_VAL so an idle line looks idle straight out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, mid-bit sampling, one-deep output register with
// valid/ready handshake, frame and overrun error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overrun_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntBit  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]      LastBit = 3'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 oerr_q, oerr_d;
  logic                 rx_s;
  logic                 rx_prev_q;

  uart_rx_sync #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      oerr_q    <= 1'b0;
      rx_prev_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      oerr_q    <= oerr_d;
      rx_prev_q <= rx_s;
    end
  end

  // Next-state, sampling and output-register update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    oerr_d  = 1'b0;

    // Consumer handshake; a byte loading on the same edge overrides this below.
    if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        // Edge-triggered only: a line stuck low after a frame error cannot restart.
        if (rx_prev_q && !rx_s) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d   = '0;
          bit_d   = '0;
          // Line back high at mid start bit: treat as a glitch.
          state_d = rx_s ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == CntBit) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_q == LastBit) begin
            state_d = StStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == CntBit) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = StIdle;
          if (!rx_s) begin
            ferr_d = 1'b1;
          end else if (valid_q && !rx_ready) begin
            oerr_d = 1'b1;
          end else begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign rx_busy     = (state_q != StIdle);
  assign frame_err   = ferr_q;
  assign overrun_err = oerr_q;

endmodule
